draw_score_bars: RTL and testbench
==================================

DRAW_SCORE_BARS -- requirements
Module: draw_score_bars

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_PLAYERS, 2, number of score markers
- BAR_W, 30, marker width in pixels
- BAR_H, 4, marker height in pixels
- MAX_SCORE, 4, highest displayable score
- STEP_Y, 24, vertical pixels per score point
- X_PITCH, 130, horizontal offset between players
- COLORS, 6'b100_111, packed 3-bit colour per player, player 0 in the LSBs
- BG_COLOR, 3'b000, erase colour
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock
- resetn, in, 1, synchronous active-low reset
- enable, in, 1, pixel-advance enable
- start, in, 1, request one redraw frame
- scores, in, 3*NUM_PLAYERS, packed per-player scores, player 0 in the LSBs
- busy, out, 1, frame in progress
- done, out, 1, one-cycle frame-complete pulse
- plot, out, 1, x/y/color valid for a framebuffer write this cycle
- x, out, 8, pixel column
- y, out, 7, pixel row
- color, out, 3, pixel colour
REQ-003 One clock; reset SHALL be synchronous and active-low, on clk and resetn.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, ERASE, DRAW, NEXT and FIN.
REQ-005 When start is high in IDLE, the block SHALL latch scores, set the player index to 0 and go to LOAD; start in any other state SHALL be ignored.
REQ-006 In LOAD, the block SHALL clamp the player score to MAX_SCORE if it is larger.
REQ-007 From LOAD, the block SHALL go to ERASE if the prev-valid flag is set and the old score differs from the new score; otherwise it SHALL go to DRAW.
REQ-008 Marker row SHALL be base_y(s) + r, where base_y(0)=1 and base_y(s)=s*STEP_Y for s>0.
REQ-009 Marker column SHALL be p*X_PITCH + c, with c in 0..BAR_W-1 and r in 0..BAR_H-1.
REQ-010 Rasterisation SHALL be one pixel per enabled cycle, c fastest, then r.
REQ-011 In ERASE, the block SHALL draw the old-score rectangle in BG_COLOR; in DRAW, it SHALL draw the new-score rectangle in COLORS[p].
REQ-012 plot SHALL be high only in ERASE or DRAW cycles with enable=1; when enable=0 the counters SHALL hold and plot SHALL be 0.
REQ-013 After the last pixel of ERASE, the FSM SHALL go to DRAW; after the last pixel of DRAW, it SHALL go to NEXT.
REQ-014 NEXT SHALL store the new score as the old score for player p.
REQ-015 NEXT SHALL go to LOAD with p+1 if p<NUM_PLAYERS-1; otherwise it SHALL set prev-valid and go to FIN.
REQ-016 FIN SHALL pulse done for exactly one cycle and return to IDLE.
REQ-017 busy SHALL be high in every state except IDLE.
REQ-018 When plot=0, x, y and color SHALL be 0.
REQ-019 Latency from the start cycle to the first plot SHALL be 2 cycles with enable held high.
REQ-020 Total plots per frame SHALL be BAR_W*BAR_H times (NUM_PLAYERS + number of changed players).
REQ-021 The scores input SHALL NOT be sampled outside the start cycle.

Reset
REQ-022 While resetn=0 at a clk edge, the block SHALL set:
- state to IDLE
- busy=0, done=0, plot=0
- x=0, y=0, color=0
- pixel counters and player index to 0
- all old scores to 0
- prev-valid to 0
REQ-023 A reset asserted mid-frame SHALL abort the frame without a done pulse, and the next frame SHALL perform no erase.

Structure
REQ-024 The shared package draw_score_pkg SHALL hold:
- the FSM state enumeration
- colour constants WHITE=3'b111 and BLACK=3'b000
- the base_y score-to-row function
REQ-025 The column/row scan SHALL be the sub-module rect_scanner, with inputs enable, clear and width/height and outputs c, r and last.
REQ-026 Width checks SHALL use parameter assertions:
- (NUM_PLAYERS-1)*X_PITCH + BAR_W <= 256
- base_y(MAX_SCORE) + BAR_H <= 128

Verification
REQ-027 Reset, then start with scores p0=1, p1=2:
- p0: 120 plots at x 0..29, y 24..27, colour 111
- p1: 120 plots at x 130..159, y 48..51, colour 100
- done after 240 plots; no erase
REQ-028 Second start with p0=3, p1=2:
- p0: 120 erase plots at y 24..27 in colour 000, then 120 plots at y 72..75
- p1: 120 draw plots only
- 360 plots total
REQ-029 Score 7 with MAX_SCORE=4 SHALL draw at y 96..99; score 0 SHALL draw at y 1..4.
REQ-030 Enable toggled every other cycle: the plot sequence SHALL be identical, the cycle count SHALL double, and no pixel SHALL be skipped or repeated.
REQ-031 start pulsed while busy SHALL be ignored; resetn dropped after 50 plots SHALL force IDLE with all outputs 0, and the next frame SHALL do no erase.

Source files
------------

// File: rtl/draw_score_pkg.sv
// rtl/draw_score_pkg.sv - shared types, colours and row mapping for the score-bar renderer
// Purpose: FSM state enumeration, colour constants and the score-to-row function.
// Ports: none (package).
package draw_score_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ERASE,
    DRAW,
    NEXT,
    FIN
  } state_t;

  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLACK = 3'b000;

  // Score 0 sits one row below the top edge so it never touches row 0.
  function automatic int base_y(input int s, input int step);
    return (s == 0) ? 1 : s * step;
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// rtl/rect_scanner.sv - column-fastest rectangle scan counter
// Purpose: walks c over 0..width-1 and r over 0..height-1, one step per enabled cycle.
// Ports:
//   clk, resetn    - clock, synchronous active-low reset
//   enable         - advance one pixel this cycle
//   clear          - force c and r back to 0 (wins over enable)
//   width, height  - rectangle size in pixels
//   c, r           - current column and row offset
//   last           - current position is the final pixel of the rectangle
module rect_scanner (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] width,
  input  logic [6:0] height,
  output logic [7:0] c,
  output logic [6:0] r,
  output logic       last
);

  logic [7:0] c_q, c_d;
  logic [6:0] r_q, r_d;
  logic       c_end;

  assign c_end = (c_q == 8'(width - 8'd1));
  assign last  = c_end && (r_q == 7'(height - 7'd1));
  assign c     = c_q;
  assign r     = r_q;

  always_comb begin
    c_d = c_q;
    r_d = r_q;
    if (clear) begin
      c_d = '0;
      r_d = '0;
    end else if (enable) begin
      if (c_end) begin
        c_d = '0;
        // Wrapping to the origin after the final pixel lets the next
        // rectangle start without a separate clear cycle.
        r_d = last ? 7'd0 : 7'(r_q + 7'd1);
      end else begin
        c_d = 8'(c_q + 8'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      c_q <= '0;
      r_q <= '0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/draw_score_bars.sv
// rtl/draw_score_bars.sv - per-player score marker renderer for a pixel framebuffer
// Purpose: on start, erases changed markers and redraws every player's marker.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   enable       - pixel-advance enable
//   start        - request one redraw frame (honoured only when idle)
//   scores       - packed 3-bit scores, player 0 in the LSBs
//   busy, done   - frame in progress / one-cycle completion pulse
//   plot, x, y, color - framebuffer write strobe and pixel (all zero when plot=0)
module draw_score_bars
  import draw_score_pkg::*;
#(
  parameter int                        NUM_PLAYERS = 2,
  parameter int                        BAR_W       = 30,
  parameter int                        BAR_H       = 4,
  parameter int                        MAX_SCORE   = 4,
  parameter int                        STEP_Y      = 24,
  parameter int                        X_PITCH     = 130,
  parameter logic [3*NUM_PLAYERS-1:0]  COLORS      = {3'b100, WHITE},
  parameter logic [2:0]                BG_COLOR    = BLACK
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       start,
  input  logic [3*NUM_PLAYERS-1:0]   scores,
  output logic                       busy,
  output logic                       done,
  output logic                       plot,
  output logic [7:0]                 x,
  output logic [6:0]                 y,
  output logic [2:0]                 color
);

  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  if ((NUM_PLAYERS - 1) * X_PITCH + BAR_W > 256) begin : g_bad_x
    $error("draw_score_bars: markers exceed 256 columns");
  end
  if (base_y(MAX_SCORE, STEP_Y) + BAR_H > 128) begin : g_bad_y
    $error("draw_score_bars: markers exceed 128 rows");
  end

  state_t                      state_q, state_d;
  logic [PW-1:0]               p_q, p_d;
  logic [3*NUM_PLAYERS-1:0]    lat_q, lat_d;
  logic [2:0]                  new_q, new_d;
  logic [2:0]                  old_q [NUM_PLAYERS];
  logic [2:0]                  old_d [NUM_PLAYERS];
  logic                        pv_q, pv_d;

  logic [2:0] raw_score, clamped, row_score;
  logic       active, scan_last;
  logic [7:0] scan_c;
  logic [6:0] scan_r;

  assign raw_score = lat_q[3*int'(p_q) +: 3];
  assign clamped   = (int'(raw_score) > MAX_SCORE) ? 3'(MAX_SCORE) : raw_score;
  assign active    = (state_q == ERASE) || (state_q == DRAW);
  assign plot      = active && enable;
  assign row_score = (state_q == ERASE) ? old_q[p_q] : new_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

  rect_scanner u_scan (
    .clk    (clk),
    .resetn (resetn),
    .enable (plot),
    .clear  (state_q == LOAD),
    .width  (8'(BAR_W)),
    .height (7'(BAR_H)),
    .c      (scan_c),
    .r      (scan_r),
    .last   (scan_last)
  );

  always_comb begin
    x     = '0;
    y     = '0;
    color = '0;
    if (plot) begin
      x     = 8'(int'(p_q) * X_PITCH + int'(scan_c));
      y     = 7'(base_y(int'(row_score), STEP_Y) + int'(scan_r));
      color = (state_q == ERASE) ? BG_COLOR : COLORS[3*int'(p_q) +: 3];
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    lat_d   = lat_q;
    new_d   = new_q;
    old_d   = old_q;
    pv_d    = pv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          lat_d   = scores;
          p_d     = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        new_d   = clamped;
        // Erase only when the screen is known to hold a different marker.
        state_d = (pv_q && (old_q[p_q] != clamped)) ? ERASE : DRAW;
      end
      ERASE: if (plot && scan_last) state_d = DRAW;
      DRAW:  if (plot && scan_last) state_d = NEXT;
      NEXT: begin
        old_d[p_q] = new_q;
        if (int'(p_q) < NUM_PLAYERS - 1) begin
          p_d     = PW'(p_q + 1'b1);
          state_d = LOAD;
        end else begin
          pv_d    = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      p_q     <= '0;
      lat_q   <= '0;
      new_q   <= '0;
      pv_q    <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) old_q[i] <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      lat_q   <= lat_d;
      new_q   <= new_d;
      pv_q    <= pv_d;
      old_q   <= old_d;
    end
  end

endmodule

// File: tb/tb_draw_score_bars.sv
// tb/tb_draw_score_bars.sv - self-checking bench for draw_score_bars
module tb_draw_score_bars;

  logic       clk = 1'b0;
  logic       resetn, enable, start;
  logic [5:0] scores;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;

  always #5 clk = ~clk;

  draw_score_bars dut (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .start  (start),
    .scores (scores),
    .busy   (busy),
    .done   (done),
    .plot   (plot),
    .x      (x),
    .y      (y),
    .color  (color)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int          m_old[2];
  bit          m_pv;
  int          first_plot, done_cnt, done_cyc, zero_bad;

  function automatic int row0(input int s);
    return (s == 0) ? 1 : s * 24;
  endfunction

  function automatic logic [2:0] pcol(input int p);
    return (p == 0) ? 3'b111 : 3'b100;
  endfunction

  function automatic void add_rect(input int p, input int s, input logic [2:0] col);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 30; c++)
        exp_q.push_back({8'(p * 130 + c), 7'(row0(s) + r), col});
  endfunction

  // Expected frame: for each player, erase the old marker if it moved, then draw the new one.
  function automatic void model_frame(input logic [5:0] sc);
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      int s;
      s = int'(sc[3*p +: 3]);
      if (s > 4) s = 4;
      if (m_pv && m_old[p] != s) add_rect(p, m_old[p], 3'b000);
      add_rect(p, s, pcol(p));
      m_old[p] = s;
    end
    m_pv = 1'b1;
  endfunction

  task automatic sample(input int n);
    if (plot) begin
      got_q.push_back({x, y, color});
      if (first_plot < 0) first_plot = n;
    end else if ({x, y, color} != 18'd0) begin
      zero_bad++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = n;
    end
  endtask

  task automatic run_frame(input string name, input logic [5:0] sc, input bit toggle, input bit abort50);
    int n;
    int nexp;
    int bad;
    model_frame(sc);
    nexp = exp_q.size();
    got_q.delete();
    first_plot = -1; done_cnt = 0; done_cyc = -1; zero_bad = 0;
    @(posedge clk); #1;
    start = 1'b1; scores = sc; enable = 1'b1;
    @(negedge clk); sample(0);
    n = 0;
    while (done_cyc < 0 && n < 4000) begin
      n++;
      @(posedge clk); #1;
      start  = (n >= 3 && n <= 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      scores = 6'($urandom);
      enable = toggle ? ((n % 2) == 0) : 1'b1;
      if (abort50 && got_q.size() == 50) begin
        resetn = 1'b0;
        start  = 1'b0;
        break;
      end
      @(negedge clk); sample(n);
    end

    if (abort50) begin
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, plot, x, y, color} !== 21'd0) begin
        n_fail++;
        $display("FAIL %s abort_outputs: got busy=%b done=%b plot=%b x=%0d y=%0d color=%b, want all 0",
                 name, busy, done, plot, x, y, color);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || plot !== 1'b0) begin
        n_fail++;
        $display("FAIL %s abort_idle: got busy=%b plot=%b, want 0 0", name, busy, plot);
      end
      n_checks++;
      if (done_cnt != 0 || got_q.size() != 50) begin
        n_fail++;
        $display("FAIL %s abort_progress: got done_cnt=%0d plots=%0d, want 0 and 50", name, done_cnt, got_q.size());
      end
      bad = 0;
      for (int i = 0; i < 50 && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s abort_prefix: got %0d wrong pixels, want 0", name, bad);
      end
      m_old[0] = 0; m_old[1] = 0; m_pv = 1'b0;
      return;
    end

    n_checks++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL %s timeout: got no done within %0d cycles, want done", name, n);
    end
    n_checks++;
    if (got_q.size() != nexp) begin
      n_fail++;
      $display("FAIL %s plot_count: got %0d, want %0d", name, got_q.size(), nexp);
    end
    bad = 0;
    for (int i = 0; i < nexp; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        bad++;
        if (bad <= 4)
          $display("FAIL %s pixel[%0d]: got %h, want %h", name, i,
                   (i < got_q.size()) ? got_q[i] : 18'h3ffff, exp_q[i]);
      end
    end
    n_checks++;
    if (zero_bad != 0) begin
      n_fail++;
      $display("FAIL %s idle_outputs_zero: got %0d nonzero cycles, want 0", name, zero_bad);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d, want 1", name, done_cnt);
    end
    if (!toggle) begin
      n_checks++;
      if (first_plot != 2) begin
        n_fail++;
        $display("FAIL %s first_plot_latency: got %0d, want 2", name, first_plot);
      end
      n_checks++;
      if (done_cyc != nexp + 5) begin
        n_fail++;
        $display("FAIL %s frame_cycles: got %0d, want %0d", name, done_cyc, nexp + 5);
      end
    end else begin
      n_checks++;
      if (done_cyc < 2 * nexp - 1 || done_cyc > 2 * nexp + 16) begin
        n_fail++;
        $display("FAIL %s toggled_frame_cycles: got %0d, want about %0d", name, done_cyc, 2 * nexp);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_frame_idle: got busy=%b done=%b, want 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; start = 1'b1; scores = 6'b010_001;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, plot, x, y, color} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b plot=%b x=%0d y=%0d color=%b, want all 0",
               busy, done, plot, x, y, color);
    end
    @(posedge clk); #1;
    start = 1'b0; resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy=%b, want 0", busy);
    end
    m_old[0] = 0; m_old[1] = 0; m_pv = 1'b0;
  endtask

  task automatic test_first_frame();
    run_frame("first_frame", 6'b010_001, 1'b0, 1'b0);
    n_checks++;
    if (got_q.size() != 240 || got_q[0] !== {8'd0, 7'd24, 3'b111} || got_q[120] !== {8'd130, 7'd48, 3'b100}) begin
      n_fail++;
      $display("FAIL first_frame_directed: got n=%0d p0=%h p1=%h, want 240 %h %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 18'h0, (got_q.size() > 120) ? got_q[120] : 18'h0,
               {8'd0, 7'd24, 3'b111}, {8'd130, 7'd48, 3'b100});
    end
  endtask

  task automatic test_erase_frame();
    run_frame("erase_frame", 6'b010_011, 1'b0, 1'b0);
    n_checks++;
    if (got_q.size() != 360 || got_q[0] !== {8'd0, 7'd24, 3'b000} || got_q[120] !== {8'd0, 7'd72, 3'b111}
        || got_q[240] !== {8'd130, 7'd48, 3'b100}) begin
      n_fail++;
      $display("FAIL erase_frame_directed: got n=%0d, want 360 with erase at y24 then draw at y72", got_q.size());
    end
  endtask

  task automatic test_clamp();
    run_frame("clamp_frame", 6'b000_111, 1'b0, 1'b0);
    n_checks++;
    if (got_q.size() != 480 || got_q[120] !== {8'd0, 7'd96, 3'b111} || got_q[479] !== {8'd159, 7'd4, 3'b100}) begin
      n_fail++;
      $display("FAIL clamp_directed: got n=%0d, want 480 with p0 at y96 and p1 ending at y4", got_q.size());
    end
  endtask

  task automatic test_enable_toggle();
    run_frame("toggle_frame", 6'b001_010, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    run_frame("abort_frame", 6'b011_100, 1'b0, 1'b1);
    run_frame("after_abort", 6'b100_011, 1'b0, 1'b0);
    n_checks++;
    if (got_q.size() != 240) begin
      n_fail++;
      $display("FAIL after_abort_no_erase: got %0d plots, want 240", got_q.size());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_frame("random_frame", 6'($urandom), 1'(k % 3 == 2), 1'b0);
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; start = 1'b0; scores = '0;
    test_reset();
    test_first_frame();
    test_erase_frame();
    test_clamp();
    test_enable_toggle();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
